// File: rtl/arb_req_pkg.sv
// Shared parameters, types and grant-decode helpers for the 4-way arbitration requester client.
package arb_req_pkg;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned WDOG_LIM   = 16;
    localparam int unsigned CH_W       = $clog2(NUM_CH);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned WDOG_W     = $clog2(WDOG_LIM + 1);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [NUM_CH-1:0] ch_vec_t;
    typedef logic [CH_W-1:0]   ch_idx_t;

    typedef struct packed {
        ch_idx_t ch;
        data_t   data;
    } out_word_t;

    // True when at most one bit is set.
    function automatic logic onehot0(input ch_vec_t v);
        return (v & (v - ch_vec_t'(1))) == '0;
    endfunction

    // Index of the lowest set bit; zero when nothing is set.
    function automatic ch_idx_t lowest_idx(input ch_vec_t v);
        ch_idx_t idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_req_if.sv
// Push, req/grant and shared-output signals between traffic sources, arbiter and the client.
interface arb_req_if;
    import arb_req_pkg::*;

    logic [NUM_CH-1:0]        push_valid;
    logic [NUM_CH-1:0]        push_ready;
    logic [NUM_CH*DATA_W-1:0] push_data;
    ch_vec_t                  req;
    ch_vec_t                  grant;
    logic                     out_valid;
    ch_idx_t                  out_ch;
    data_t                    out_data;
    logic [CNT_W-1:0]         wasted_cnt;
    logic                     err_multi_grant;
    ch_vec_t                  starve;

    modport master (
        output push_valid, push_data, grant,
        input  push_ready, req, out_valid, out_ch, out_data,
        input  wasted_cnt, err_multi_grant, starve
    );

    modport slave (
        input  push_valid, push_data, grant,
        output push_ready, req, out_valid, out_ch, out_data,
        output wasted_cnt, err_multi_grant, starve
    );

endinterface

// File: rtl/arb_req_chan_fifo.sv
// Per-channel synchronous FIFO; pushes while full and pops while empty are ignored.
module arb_req_chan_fifo
    import arb_req_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && (r_count != FULL_CNT);
    assign w_pop  = i_pop && (r_count != '0);

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/arb_req_client.sv
// Requester-side arbitration client: per-channel FIFOs, grant decode and shared output bus.
// Optional per-channel starvation watchdog enabled by defining ARB_REQ_WDOG_EN.
module arb_req_client
    import arb_req_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    arb_req_if.slave  bus
);

    ch_vec_t          w_full;
    ch_vec_t          w_empty;
    ch_vec_t          w_req;
    ch_vec_t          w_pop;
    data_t            w_head  [NUM_CH];
    logic [PTR_W:0]   w_count [NUM_CH];
    logic             w_grant_any;
    ch_idx_t          w_sel;
    logic             w_sel_has_word;
    logic             w_do_pop;

    out_word_t        r_out;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_wasted;
    logic             r_err_multi;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        arb_req_chan_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (DATA_W)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (bus.push_valid[g]),
            .i_data  (bus.push_data[g*DATA_W +: DATA_W]),
            .i_pop   (w_pop[g]),
            .o_head  (w_head[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_count (w_count[g])
        );
    end

    // Only the lowest granted channel is served; a grant to a drained channel is wasted.
    assign w_grant_any    = |bus.grant;
    assign w_sel          = lowest_idx(bus.grant);
    assign w_sel_has_word = (w_count[w_sel] != '0);
    assign w_do_pop       = w_grant_any && w_sel_has_word;
    assign w_req          = ~w_empty;

    always_comb begin
        w_pop = '0;
        if (w_do_pop) w_pop[w_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_wasted    <= '0;
            r_err_multi <= 1'b0;
        end else begin
            r_out_valid <= w_do_pop;
            if (w_do_pop) begin
                r_out.ch   <= w_sel;
                r_out.data <= w_head[w_sel];
            end
            if (w_grant_any && !w_sel_has_word && (r_wasted != '1)) begin
                r_wasted <= r_wasted + CNT_W'(1);
            end
            if (!onehot0(bus.grant)) r_err_multi <= 1'b1;
        end
    end

`ifdef ARB_REQ_WDOG_EN
    logic [WDOG_W-1:0] r_wdog [NUM_CH];
    ch_vec_t           r_starve;

    // Counts consecutive requesting cycles without a grant; starve latches at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) r_wdog[i] <= '0;
            r_starve <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_req[i] || bus.grant[i]) begin
                    r_wdog[i] <= '0;
                end else if (r_wdog[i] != WDOG_W'(WDOG_LIM)) begin
                    r_wdog[i] <= r_wdog[i] + WDOG_W'(1);
                    if (r_wdog[i] == WDOG_W'(WDOG_LIM - 1)) r_starve[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.starve = r_starve;
`else
    assign bus.starve = '0;
`endif

    assign bus.req             = w_req;
    assign bus.push_ready      = ~w_full;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_ch          = r_out.ch;
    assign bus.out_data        = r_out.data;
    assign bus.wasted_cnt      = r_wasted;
    assign bus.err_multi_grant = r_err_multi;

endmodule
